rfx_trigger_gen: RTL and testbench

//  Periodic trigger/burst generator driven by the rfx_prescaler tick strobe (downstream stage).
//  - Counts prescaled ticks and emits a train of pulses with programmable period, high width and pulse count.
//  - Config ports are fed from AXI-lite slave registers.
//  - trig_out feeds RFX timing/acquisition logic.

---
 rtl/rfx_trigger_gen.sv | 105 ++++++++++
 tb/tb_rfx_trigger_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rfx_trigger_gen.sv
// rfx_trigger_gen: tick-driven periodic trigger/burst generator (period, high width, pulse count).
// Ports: ACLK/ARESET (async active-high) clock/reset; tick_in prescaler enable; start/stop train control;
// cfg_period/cfg_width/cfg_count train config; trig_out trigger; busy train running; done completion pulse;
// cfg_err sticky rejected start; pulse_idx completed periods. Optional: RFX_TRIGGEN_RETRIG_EN (restart on start while running).
module rfx_trigger_gen #(
    parameter int CNT_WIDTH = 32,
    parameter int IDX_WIDTH = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 tick_in,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_width,
    input  logic [IDX_WIDTH-1:0] cfg_count,
    output logic                 trig_out,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [IDX_WIDTH-1:0] pulse_idx
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] period_l, period_n, width_l, width_n, ph, ph_n, ph_inc;
    logic [IDX_WIDTH-1:0] count_l, count_n, idx_n;
    logic                 trig_n, busy_n, done_n, err_n, ph_wrap, last, cfg_ok, try_start;
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= IDLE;
            period_l  <= '0;
            width_l   <= '0;
            count_l   <= '0;
            ph        <= '0;
            pulse_idx <= '0;
            trig_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_n;
            period_l  <= period_n;
            width_l   <= width_n;
            count_l   <= count_n;
            ph        <= ph_n;
            pulse_idx <= idx_n;
            trig_out  <= trig_n;
            busy      <= busy_n;
            done      <= done_n;
            cfg_err   <= err_n;
        end
    end
    always_comb begin
        state_n  = state;
        period_n = period_l;
        width_n  = width_l;
        count_n  = count_l;
        ph_n     = ph;
        idx_n    = pulse_idx;
        trig_n   = trig_out;
        busy_n   = busy;
        done_n   = 1'b0;
        err_n    = cfg_err;
        cfg_ok   = cfg_period != '0 && cfg_width <= cfg_period;
`ifdef RFX_TRIGGEN_RETRIG_EN
        try_start = start;
`else
        try_start = start && state == IDLE;
`endif
        ph_wrap  = ph == period_l - CNT_WIDTH'(1);
        ph_inc   = ph_wrap ? '0 : ph + CNT_WIDTH'(1);
        last     = count_l != '0 && pulse_idx == count_l - IDX_WIDTH'(1);
        if (stop) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            trig_n  = 1'b0;
        end else if (try_start && cfg_ok) begin
            state_n  = RUN;
            period_n = cfg_period;
            width_n  = cfg_width;
            count_n  = cfg_count;
            ph_n     = '0;
            idx_n    = '0;
            err_n    = 1'b0;
            busy_n   = 1'b1;
            trig_n   = cfg_width != '0;
        end else begin
            // A rejected start flags the error but never disturbs a running train
            err_n = try_start ? 1'b1 : cfg_err;
            if (state == RUN && tick_in) begin
                ph_n   = ph_inc;
                trig_n = ph_inc < width_l;
                if (ph_wrap) begin
                    idx_n = pulse_idx + IDX_WIDTH'(1);
                    if (last) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        trig_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rfx_trigger_gen.sv
// tb_rfx_trigger_gen: randomized check of rfx_trigger_gen against a tick-count reference model.
module tb_rfx_trigger_gen;
`ifdef RFX_TRIGGEN_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif
    logic        tb_ACLK = 1'b0;
    logic        ARESET, tick_in, start, stop;
    logic [31:0] cfg_period, cfg_width;
    logic [15:0] cfg_count;
    logic        trig_out, busy, done, cfg_err;
    logic [15:0] pulse_idx;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          m_busy, m_done, m_err;
    int          m_P, m_W, m_N, m_idx_hold;
    longint      m_t;

    rfx_trigger_gen dut (
        .ACLK(tb_ACLK), .ARESET(ARESET), .tick_in(tick_in), .start(start), .stop(stop),
        .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_count(cfg_count),
        .trig_out(trig_out), .busy(busy), .done(done), .cfg_err(cfg_err), .pulse_idx(pulse_idx)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_err = 0;
        m_P = 1; m_W = 0; m_N = 0; m_t = 0; m_idx_hold = 0;
    endtask

    // Train position is just the number of ticks since start: phase = t mod P, index = t / P
    function automatic int cur_idx();
        return int'((m_t / m_P) % 65536);
    endfunction

    task automatic model_step();
        bit go, ok;
        m_done = 0;
        go = start && (!m_busy || RETRIG);
        ok = cfg_period != 0 && cfg_width <= cfg_period;
        if (stop) begin
            if (m_busy) m_idx_hold = cur_idx();
            m_busy = 0;
        end else if (go && ok) begin
            m_busy = 1; m_t = 0; m_err = 0;
            m_P = int'(cfg_period); m_W = int'(cfg_width); m_N = int'(cfg_count);
        end else begin
            if (go) m_err = 1;
            if (m_busy && tick_in) begin
                m_t++;
                if (m_N != 0 && m_t == longint'(m_N) * m_P) begin
                    m_busy = 0; m_done = 1; m_idx_hold = m_N;
                end
            end
        end
    endtask

    task automatic check_model(input string pfx);
        check({pfx, "_busy"}, busy, m_busy);
        check({pfx, "_trig"}, trig_out, m_busy && (m_t % m_P) < m_W);
        check({pfx, "_done"}, done, m_done);
        check({pfx, "_err"}, cfg_err, m_err);
        check({pfx, "_idx"}, pulse_idx, m_busy ? cur_idx() : m_idx_hold);
    endtask

    task automatic cycle(input string pfx);
        @(posedge tb_ACLK);
        model_step();
        @(negedge tb_ACLK);
        check_model(pfx);
    endtask

    task automatic set_cfg(input int p, input int w, input int n);
        cfg_period = p; cfg_width = w; cfg_count = 16'(n);
    endtask

    initial begin
        ARESET = 1; tick_in = 0; start = 0; stop = 0;
        set_cfg(0, 0, 0);
        model_reset();
        repeat (3) @(negedge tb_ACLK);
        check_model("rst");
        ARESET = 0;
        // T1: period 4, width 1, count 3, tick every cycle
        set_cfg(4, 1, 3); tick_in = 1; start = 1;
        for (int c = 1; c <= 15; c++) begin
            cycle("t1");
            start = 0;
            check("t1_trig_c", trig_out, c == 1 || c == 5 || c == 9);
            check("t1_done_c", done, c == 13);
            check("t1_busy_c", busy, c >= 1 && c <= 12);
        end
        check("t1_idx_c", pulse_idx, 3);
        // T3: rejected configs, then recovery
        set_cfg(5, 6, 0); start = 1;
        cycle("t3a");
        check("t3_err_c", cfg_err, 1);
        set_cfg(5, 2, 1);
        cycle("t3b");
        check("t3_clr_c", cfg_err, 0);
        start = 0; stop = 1;
        cycle("t3c");
        stop = 0; set_cfg(0, 0, 0); start = 1;
        cycle("t3d");
        check("t3_p0_c", cfg_err, 1);
        // T5: start&stop in IDLE, then async reset mid-train
        set_cfg(3, 2, 0); stop = 1;
        cycle("t5a");
        check("t5_nostart_c", busy, 0);
        stop = 0;
        cycle("t5b");
        start = 0;
        repeat (5) cycle("t5c");
        #2 ARESET = 1;
        #1;
        model_reset();
        check_model("t5_arst");
        @(negedge tb_ACLK);
        ARESET = 0;
        // Randomized mix: tick always, prescaler /3, random ticks
        for (int i = 0; i < 3000; i++) begin
            tick_in = i < 1000 ? 1'b1 : i < 2000 ? (i % 3 == 0) : 1'($urandom);
            start = $urandom_range(0, m_busy ? 19 : 5) == 0;
            stop = $urandom_range(0, 39) == 0;
            cfg_period = $urandom_range(0, 6);
            cfg_width = $urandom_range(0, cfg_period + 1);
            cfg_count = 16'($urandom_range(0, 4));
            cycle("rnd");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
